// File: rtl/prime_factor_engine.sv
// Trial-division primality engine: loads an NBITS operand in CHUNK-wide pieces,
// then divides by 2, 3, 5, 7, ... with a bit-serial restoring remainder unit.
module prime_factor_engine #(
    parameter int unsigned NBITS = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHUNK-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_prime,
    output logic [NBITS-1:0] factor,
    output logic             busy
);

    localparam int unsigned NCHUNK = NBITS / CHUNK;
    localparam int unsigned CNT_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned RW     = NBITS + 1;
    localparam int unsigned SQW    = 2 * NBITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        DIVIDE = 3'd3,
        EVAL   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state, state_next;

    logic [NBITS-1:0] n_q, n_sh_q, d_q;
    logic [RW-1:0]    r_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NBITS-1:0] n_nx, n_sh_nx, d_nx, factor_nx;
    logic [RW-1:0]    r_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             is_prime_nx, in_ready_nx, out_valid_nx, busy_nx;

    logic             accept_c, last_chunk_c, last_bit_c;
    logic             small_c, tiny_prime_c, r_zero_c, sq_gt_c;
    logic [RW-1:0]    r_shift_c, r_step_c, d_ext_c, d_cand_c;
    logic [SQW-1:0]   d_cand_w_c, d_sq_c;

    // Shared datapath terms
    always_comb begin
        accept_c     = in_valid && in_ready;
        last_chunk_c = (cnt_q == CNT_W'(NCHUNK - 1));
        last_bit_c   = (cnt_q == CNT_W'(NBITS - 1));
        small_c      = (n_q < NBITS'(2));
        tiny_prime_c = (n_q == NBITS'(2)) || (n_q == NBITS'(3));
        r_zero_c     = (r_q == '0);
        // Restoring step: shift in the next operand bit, subtract d when it fits
        r_shift_c    = {r_q[NBITS-1:0], n_sh_q[NBITS-1]};
        d_ext_c      = RW'(d_q);
        r_step_c     = (r_shift_c >= d_ext_c) ? (r_shift_c - d_ext_c) : r_shift_c;
        d_cand_c     = (d_q == NBITS'(2)) ? RW'(3) : (RW'(d_q) + RW'(2));
        d_cand_w_c   = SQW'(d_cand_c);
        d_sq_c       = d_cand_w_c * d_cand_w_c;
        sq_gt_c      = (d_sq_c > SQW'(n_q));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, LOAD: begin
                if (accept_c) state_next = last_chunk_c ? CHECK : LOAD;
            end
            CHECK: begin
                if (small_c || tiny_prime_c) state_next = DONE;
                else                         state_next = DIVIDE;
            end
            DIVIDE: begin
                if (last_bit_c) state_next = EVAL;
            end
            EVAL: begin
                if (r_zero_c || sq_gt_c) state_next = DONE;
                else                     state_next = DIVIDE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        in_ready_nx  = (state_next == IDLE) || (state_next == LOAD);
        out_valid_nx = (state_next == DONE);
        busy_nx      = (state_next == CHECK) || (state_next == DIVIDE) || (state_next == EVAL);
        n_nx         = n_q;
        n_sh_nx      = n_sh_q;
        d_nx         = d_q;
        r_nx         = r_q;
        cnt_nx       = cnt_q;
        is_prime_nx  = is_prime;
        factor_nx    = factor;
        unique case (state)
            IDLE, LOAD: begin
                if (accept_c) begin
                    n_nx   = NBITS'({n_q, in_data});
                    cnt_nx = last_chunk_c ? '0 : (cnt_q + CNT_W'(1));
                end
            end
            CHECK: begin
                if (small_c) begin
                    is_prime_nx = 1'b0;
                    factor_nx   = '0;
                end else if (tiny_prime_c) begin
                    is_prime_nx = 1'b1;
                    factor_nx   = n_q;
                end else begin
                    d_nx    = NBITS'(2);
                    r_nx    = '0;
                    cnt_nx  = '0;
                    n_sh_nx = n_q;
                end
            end
            DIVIDE: begin
                r_nx    = r_step_c;
                n_sh_nx = n_sh_q << 1;
                cnt_nx  = last_bit_c ? '0 : (cnt_q + CNT_W'(1));
            end
            EVAL: begin
                if (r_zero_c) begin
                    is_prime_nx = 1'b0;
                    factor_nx   = d_q;
                end else if (sq_gt_c) begin
                    is_prime_nx = 1'b1;
                    factor_nx   = n_q;
                end else begin
                    d_nx    = NBITS'(d_cand_c);
                    r_nx    = '0;
                    cnt_nx  = '0;
                    n_sh_nx = n_q;
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            is_prime  <= 1'b0;
            factor    <= '0;
            n_q       <= '0;
            n_sh_q    <= '0;
            d_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
        end else begin
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
            is_prime  <= is_prime_nx;
            factor    <= factor_nx;
            n_q       <= n_nx;
            n_sh_q    <= n_sh_nx;
            d_q       <= d_nx;
            r_q       <= r_nx;
            cnt_q     <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_prime_factor_engine.sv
// Directed bench for prime_factor_engine (16/4 and 8/2 instances) against an
// arithmetic trial-division model with per-cycle output checking.
module tb_prime_factor_engine;

    localparam int unsigned NB = 16, CK = 4, NB8 = 8, CK8 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          iv, ir, ov, ordy, ip, bz;
    logic [CK-1:0] id;
    logic [NB-1:0] fac;
    logic           iv8, ir8, ov8, ordy8, ip8, bz8;
    logic [CK8-1:0] id8;
    logic [NB8-1:0] fac8;

    prime_factor_engine #(.NBITS(NB), .CHUNK(CK)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .in_data(id),
        .out_valid(ov), .out_ready(ordy), .is_prime(ip), .factor(fac), .busy(bz));

    prime_factor_engine #(.NBITS(NB8), .CHUNK(CK8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(ordy8), .is_prime(ip8), .factor(fac8), .busy(bz8));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Smallest factor by plain trial division; k counts divisors tried
    function automatic void model(input longint unsigned n, output bit p,
                                  output longint unsigned f, output int k);
        longint unsigned d, dn;
        k = 0; p = 1'b0; f = 0;
        if (n < 2) return;
        if (n < 4) begin p = 1'b1; f = n; return; end
        d = 2;
        for (int g = 0; g < 100000; g++) begin
            k++;
            if (n % d == 0) begin p = 1'b0; f = d; return; end
            dn = (d == 2) ? 3 : d + 2;
            if (dn * dn > n) begin p = 1'b1; f = n; return; end
            d = dn;
        end
    endfunction

    logic            chk_on = 1'b0;
    int              acc_cyc, exp_lat;
    bit              exp_p;
    longint unsigned exp_f;

    // Per-cycle comparison of the 16-bit instance against the model timeline
    always @(negedge clk) begin
        int el;
        if (chk_on) begin
            el = cyc - acc_cyc;
            chk("out_valid", ov, 64'(el >= exp_lat));
            chk("in_ready_busy", ir, 0);
            chk("busy", bz, 64'(el < exp_lat));
            if (ov) begin
                chk("is_prime", ip, exp_p);
                chk("factor", fac, exp_f);
            end
        end
    end

    task automatic send16(input logic [CK-1:0] c);
        @(negedge clk);
        chk("in_ready_load", ir, 1);
        iv = 1'b1; id = c;
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic load16(input logic [NB-1:0] n);
        for (int i = NB / CK - 1; i >= 0; i--) send16(CK'(n >> (i * CK)));
    endtask

    task automatic run16(input logic [NB-1:0] n, input int hold, input bit noise,
                         input int lit_lat, input bit lit_p, input logic [NB-1:0] lit_f);
        bit p; longint unsigned f; int k, meas;
        model(64'(n), p, f, k);
        chk("model_latency", 1 + k * (NB + 1), lit_lat);
        chk("model_prime", p, lit_p);
        chk("model_factor", f, lit_f);
        load16(n);
        acc_cyc = cyc; exp_lat = 1 + k * (NB + 1); exp_p = p; exp_f = f;
        chk_on = 1'b1;
        if (noise) begin iv = 1'b1; id = CK'($urandom); end
        meas = -1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (ov) begin meas = cyc - acc_cyc; break; end
        end
        iv = 1'b0;
        chk("latency", meas, lit_lat);
        if (meas < 0) begin
            chk_on = 1'b0;
            reset = 1'b1; @(negedge clk); reset = 1'b0;
            return;
        end
        repeat (hold) @(negedge clk);
        ordy = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b0; ordy = 1'b0;
        chk("release_out_valid", ov, 0);
        chk("release_in_ready", ir, 1);
        chk("release_busy", bz, 0);
    endtask

    task automatic run8(input logic [NB8-1:0] n, input int lit_lat, input bit lit_p,
                        input logic [NB8-1:0] lit_f);
        bit p; longint unsigned f; int k, meas, acc;
        model(64'(n), p, f, k);
        chk("model8_latency", 1 + k * (NB8 + 1), lit_lat);
        chk("model8_factor", f, lit_f);
        for (int i = NB8 / CK8 - 1; i >= 0; i--) begin
            @(negedge clk);
            iv8 = 1'b1; id8 = CK8'(n >> (i * CK8));
            @(posedge clk); #1;
            iv8 = 1'b0;
        end
        acc = cyc; meas = -1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (ov8) begin meas = cyc - acc; break; end
            chk("in_ready8_busy", ir8, 0);
        end
        chk("latency8", meas, 1 + k * (NB8 + 1));
        chk("is_prime8", ip8, lit_p);
        chk("factor8", fac8, lit_f);
        ordy8 = 1'b1;
        @(posedge clk); #1;
        ordy8 = 1'b0;
        chk("release8_out_valid", ov8, 0);
        chk("release8_in_ready", ir8, 1);
    endtask

    initial begin
        reset = 1'b1; iv = 1'b0; id = '0; ordy = 1'b0;
        iv8 = 1'b0; id8 = '0; ordy8 = 1'b0;
        #12;
        chk("rst_in_ready", ir, 1);
        chk("rst_out_valid", ov, 0);
        chk("rst_is_prime", ip, 0);
        chk("rst_factor", fac, 0);
        chk("rst_busy", bz, 0);
        chk("rst8_in_ready", ir8, 1);
        @(negedge clk); reset = 1'b0;

        run16(16'h0007, 0, 1'b0, 18, 1'b1, 16'h0007);
        run16(16'h0009, 0, 1'b1, 35, 1'b0, 16'h0003);
        run16(16'h0000, 0, 1'b0, 1, 1'b0, 16'h0000);
        run16(16'h0001, 0, 1'b0, 1, 1'b0, 16'h0000);
        run16(16'h0002, 0, 1'b0, 1, 1'b1, 16'h0002);
        run16(16'h0003, 0, 1'b0, 1, 1'b1, 16'h0003);
        run16(16'h0019, 2, 1'b0, 52, 1'b0, 16'h0005);
        run16(16'hFFF1, 0, 1'b0, 2177, 1'b1, 16'hFFF1);
        run16(16'hFFFF, 0, 1'b0, 35, 1'b0, 16'h0003);
        run16(16'hFFFF, 10, 1'b1, 35, 1'b0, 16'h0003);

        // Reset in the middle of a long division
        load16(16'hFFF1);
        repeat (40) @(negedge clk);
        chk("pre_reset_busy", bz, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", ov, 0);
        chk("midrst_in_ready", ir, 1);
        chk("midrst_busy", bz, 0);
        chk("midrst_is_prime", ip, 0);
        chk("midrst_factor", fac, 0);
        @(negedge clk); reset = 1'b0;
        run16(16'h0004, 0, 1'b0, 18, 1'b0, 16'h0002);

        // Reset mid-load discards the partial operand
        send16(4'hF);
        send16(4'hF);
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        run16(16'h0007, 0, 1'b0, 18, 1'b1, 16'h0007);

        run8(8'hFB, 73, 1'b1, 8'hFB);
        run8(8'h79, 55, 1'b0, 8'h0B);
        run8(8'hFF, 19, 1'b0, 8'h03);
        run8(8'h02, 1, 1'b1, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prime_factor_engine.md
Name: prime_factor_engine

Overview:
- Parametrised successor to the 16-bit prime detector core.
- Accepts an NBITS-wide operand over a narrow chunked input bus with valid/ready, then runs iterative trial division.
- Trial divisors are 2, 3, 5, 7, … up to floor(sqrt(n)); each remainder is computed by a bit-serial restoring divider.
- Reports prime/composite plus the smallest factor, and holds the result under output backpressure.
- Sits behind the pin-limited top-level wrapper; chunk width matches the available input pins.

Parameters:
- NBITS, 16, operand width. Legal when NBITS >= 4 and NBITS % CHUNK == 0.
- CHUNK, 4, input chunk width. Operand loads as NBITS/CHUNK chunks, MSB chunk first.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  in_data holds a valid chunk.
- in_ready  out  1  engine can accept a chunk.
- in_data  in  CHUNK  operand chunk, MSB chunk first.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- is_prime  out  1  1 if the operand is prime.
- factor  out  NBITS  smallest factor >= 2; equals n if n is prime; 0 if n < 2.
- busy  out  1  high in CHECK, DIVIDE or EVAL.

Behaviour:
- Reset values (applied asynchronously):
  - state=IDLE, in_ready=1, out_valid=0, is_prime=0, factor=0, busy=0.
  - Chunk count, operand, divisor and remainder registers all cleared to 0.
- States: IDLE, LOAD, CHECK, DIVIDE, EVAL, DONE.
- IDLE / LOAD (in_ready=1):
  - Each in_valid&&in_ready edge shifts in_data into the operand LSB end: n <= {n[NBITS-CHUNK-1:0], in_data}.
  - The chunk counter increments on each accepted chunk; state is LOAD after the first chunk.
  - On the edge accepting chunk NBITS/CHUNK: counter returns to 0, state -> CHECK.
  - in_valid low leaves state and partial operand unchanged; loading has no timeout.
- CHECK (1 cycle):
  - n < 2: is_prime=0, factor=0, -> DONE.
  - n == 2 or n == 3: is_prime=1, factor=n, -> DONE.
  - Otherwise: d=2, clear remainder, -> DIVIDE.
- DIVIDE (exactly NBITS cycles):
  - Restoring remainder r = n mod d, one operand bit per cycle, MSB first.
  - r is NBITS+1 bits wide so the trial subtract cannot overflow.
  - After NBITS cycles -> EVAL.
- EVAL (1 cycle):
  - r == 0: is_prime=0, factor=d, -> DONE.
  - Otherwise d_next = 3 if d == 2, else d+2.
  - If d_next*d_next > n (compare at 2*NBITS width, no overflow): is_prime=1, factor=n, -> DONE.
  - Else d <= d_next, -> DIVIDE.
- DONE:
  - out_valid=1; is_prime and factor held stable while out_ready=0.
  - On the out_valid&&out_ready edge: out_valid=0, -> IDLE.
  - in_ready=1 from the following cycle.
- in_ready=0 in CHECK, DIVIDE, EVAL and DONE. Chunks presented then are not consumed; in_valid there is ignored.
- Latency: with k = number of divisors tried, out_valid rises 1 + k*(NBITS+1) edges after the edge that accepted the last chunk.
- Simultaneous events:
  - The final-chunk accept and the state change to CHECK occur on the same edge.
  - In DONE the input cannot be accepted in the same cycle as the output is released (in_ready=0).
- Reset asserted mid-load or mid-division:
  - Immediate return to reset values; the partial operand is discarded.
  - The first chunk after reset deassertion is treated as the MSB chunk.

Test Plan:
- Defaults, chunks 0,0,0,7 -> out_valid 18 edges after the last accept; is_prime=1, factor=0x0007.
- Chunks giving 9 -> k=2, latency 35; is_prime=0, factor=3.
- Boundaries:
  - n=0 -> is_prime=0, factor=0, latency 1.
  - n=1 -> is_prime=0, factor=0, latency 1.
  - n=2 -> is_prime=1, factor=2, latency 1.
- n=0xFFF1 (65521) -> k=128, latency 2177, is_prime=1, factor=0xFFF1.
- n=0xFFFF -> is_prime=0, factor=3.
- n=0xFFFF with out_ready=0 for 10 cycles -> result held and in_ready=0 throughout; then release -> out_valid=0 next edge.
- Reset raised mid-DIVIDE on n=0xFFF1, then n=4 loaded -> all outputs at reset values immediately; then is_prime=0, factor=2.
- NBITS=8, CHUNK=2, n=0xFB (251) -> prime, factor=0xFB, k=8, latency 73.
